cbus_xlate_bridge: RTL and testbench



---
 rtl/cbus_xlate_bridge.sv | 192 +++++++++++++++++++
 tb/tb_cbus_xlate_bridge.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cbus_xlate_bridge.sv
// rtl/cbus_xlate_bridge.sv - registered CBus-to-external-bus bridge with kseg0/kseg1 address translation
//
// Captures one arbiter request per transaction, translates its address and
// holds the translated request stable for the entire burst. The response
// path from the external bus back to the arbiter is purely combinational.
//
// Ports:
//   clk, resetn            clock, asynchronous active-low reset
//   ireq_*_i               arbiter request (valid, is_write, size, addr,
//                          strobe, data, len, burst)
//   iresp_*_o              response to the arbiter (ready, last, data)
//   oreq_*_o               translated request to the external bus
//   oresp_*_i              external bus response (ready, last, data)
//   err_o                  sticky protocol-error flag
//   busy_o                 high while a transaction is outstanding
module cbus_xlate_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4
) (
  input  logic                clk,
  input  logic                resetn,

  input  logic                ireq_valid_i,
  input  logic                ireq_is_write_i,
  input  logic [2:0]          ireq_size_i,
  input  logic [ADDR_W-1:0]   ireq_addr_i,
  input  logic [DATA_W/8-1:0] ireq_strobe_i,
  input  logic [DATA_W-1:0]   ireq_data_i,
  input  logic [LEN_W-1:0]    ireq_len_i,
  input  logic [1:0]          ireq_burst_i,

  output logic                iresp_ready_o,
  output logic                iresp_last_o,
  output logic [DATA_W-1:0]   iresp_data_o,

  output logic                oreq_valid_o,
  output logic                oreq_is_write_o,
  output logic [2:0]          oreq_size_o,
  output logic [ADDR_W-1:0]   oreq_addr_o,
  output logic [DATA_W/8-1:0] oreq_strobe_o,
  output logic [DATA_W-1:0]   oreq_data_o,
  output logic [LEN_W-1:0]    oreq_len_o,
  output logic [1:0]          oreq_burst_o,

  input  logic                oresp_ready_i,
  input  logic                oresp_last_i,
  input  logic [DATA_W-1:0]   oresp_data_i,

  output logic                err_o,
  output logic                busy_o
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  state_e              state_q, state_d;

  // Holding register for the captured request.
  logic                is_write_q, is_write_d;
  logic [2:0]          size_q, size_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [1:0]          burst_q, burst_d;

  logic [LEN_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic                err_q, err_d;

  logic                capture;
  logic                beat;
  logic                beat_final;

  // kseg0/kseg1 (top bits 2'b10) map onto the low 512 MB of physical space;
  // every other segment passes through untouched.
  function automatic logic [ADDR_W-1:0] xlate(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] r;
    r = a;
    if (a[ADDR_W-1:ADDR_W-2] == 2'b10) begin
      r[ADDR_W-1:ADDR_W-3] = 3'b000;
    end
    return r;
  endfunction

  assign capture    = (state_q == ST_IDLE) && ireq_valid_i;
  assign beat       = (state_q == ST_BUSY) && oresp_ready_i;
  assign beat_final = beat && oresp_last_i;

  // State register and datapath registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      is_write_q <= 1'b0;
      size_q     <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      burst_q    <= '0;
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_write_q <= is_write_d;
      size_q     <= size_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      burst_q    <= burst_d;
      beat_cnt_q <= beat_cnt_d;
      err_q      <= err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (ireq_valid_i) state_d = ST_BUSY;
      ST_BUSY: if (beat_final)   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Holding register, beat counter and sticky error.
  always_comb begin
    is_write_d = is_write_q;
    size_d     = size_q;
    addr_d     = addr_q;
    len_d      = len_q;
    burst_d    = burst_q;
    beat_cnt_d = beat_cnt_q;
    err_d      = err_q;

    if (capture) begin
      is_write_d = ireq_is_write_i;
      size_d     = ireq_size_i;
      addr_d     = xlate(ireq_addr_i);
      len_d      = ireq_len_i;
      burst_d    = ireq_burst_i;
      beat_cnt_d = '0;
    end else if (beat && (beat_cnt_q != {LEN_W{1'b1}})) begin
      beat_cnt_d = beat_cnt_q + 1'b1;
    end

    // beat_cnt_q holds the number of beats already completed, so the current
    // beat is the final legal one exactly when it equals len_q.
    if ((state_q == ST_IDLE) && oresp_ready_i) begin
      err_d = 1'b1;
    end
    if (beat && oresp_last_i && (beat_cnt_q != len_q)) begin
      err_d = 1'b1;
    end
    if (beat && !oresp_last_i && (beat_cnt_q == len_q)) begin
      err_d = 1'b1;
    end
  end

  // Output logic. Everything downstream-facing is forced low in IDLE so the
  // external bus never sees stale fields; in BUSY the control fields come from
  // the holding register while write data and strobes track ireq per beat.
  always_comb begin
    oreq_valid_o    = 1'b0;
    oreq_is_write_o = 1'b0;
    oreq_size_o     = '0;
    oreq_addr_o     = '0;
    oreq_strobe_o   = '0;
    oreq_data_o     = '0;
    oreq_len_o      = '0;
    oreq_burst_o    = '0;
    iresp_ready_o   = 1'b0;
    iresp_last_o    = 1'b0;
    iresp_data_o    = '0;
    busy_o          = 1'b0;

    if (state_q == ST_BUSY) begin
      busy_o          = 1'b1;
      oreq_valid_o    = 1'b1;
      oreq_is_write_o = is_write_q;
      oreq_size_o     = size_q;
      oreq_addr_o     = addr_q;
      oreq_len_o      = len_q;
      oreq_burst_o    = burst_q;
      oreq_strobe_o   = ireq_strobe_i;
      oreq_data_o     = ireq_data_i;
      iresp_ready_o   = oresp_ready_i;
      iresp_last_o    = oresp_last_i;
      iresp_data_o    = oresp_data_i;
    end
  end

  assign err_o = err_q;

endmodule

// File: tb/tb_cbus_xlate_bridge.sv
// tb/tb_cbus_xlate_bridge.sv - directed self-checking bench for cbus_xlate_bridge
module tb_cbus_xlate_bridge;

  logic        clk;
  logic        resetn;
  logic        ireq_valid, ireq_is_write;
  logic [2:0]  ireq_size;
  logic [31:0] ireq_addr;
  logic [3:0]  ireq_strobe;
  logic [31:0] ireq_data;
  logic [3:0]  ireq_len;
  logic [1:0]  ireq_burst;
  logic        iresp_ready, iresp_last;
  logic [31:0] iresp_data;
  logic        oreq_valid, oreq_is_write;
  logic [2:0]  oreq_size;
  logic [31:0] oreq_addr;
  logic [3:0]  oreq_strobe;
  logic [31:0] oreq_data;
  logic [3:0]  oreq_len;
  logic [1:0]  oreq_burst;
  logic        oresp_ready, oresp_last;
  logic [31:0] oresp_data;
  logic        err, busy;

  int n_checks = 0;
  int n_fail   = 0;

  cbus_xlate_bridge dut (
    .clk             (clk),
    .resetn          (resetn),
    .ireq_valid_i    (ireq_valid),
    .ireq_is_write_i (ireq_is_write),
    .ireq_size_i     (ireq_size),
    .ireq_addr_i     (ireq_addr),
    .ireq_strobe_i   (ireq_strobe),
    .ireq_data_i     (ireq_data),
    .ireq_len_i      (ireq_len),
    .ireq_burst_i    (ireq_burst),
    .iresp_ready_o   (iresp_ready),
    .iresp_last_o    (iresp_last),
    .iresp_data_o    (iresp_data),
    .oreq_valid_o    (oreq_valid),
    .oreq_is_write_o (oreq_is_write),
    .oreq_size_o     (oreq_size),
    .oreq_addr_o     (oreq_addr),
    .oreq_strobe_o   (oreq_strobe),
    .oreq_data_o     (oreq_data),
    .oreq_len_o      (oreq_len),
    .oreq_burst_o    (oreq_burst),
    .oresp_ready_i   (oresp_ready),
    .oresp_last_i    (oresp_last),
    .oresp_data_i    (oresp_data),
    .err_o           (err),
    .busy_o          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input logic v, input logic we, input logic [31:0] a, input logic [3:0] l);
    ireq_valid    = v;
    ireq_is_write = we;
    ireq_addr     = a;
    ireq_len      = l;
    ireq_size     = 3'd2;
    ireq_burst    = 2'd1;
    ireq_strobe   = 4'hF;
  endtask

  task automatic set_resp(input logic r, input logic l, input logic [31:0] d);
    oresp_ready = r;
    oresp_last  = l;
    oresp_data  = d;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    set_req(1'b0, 1'b0, 32'h0, 4'h0);
    ireq_data = 32'h0;
    set_resp(1'b0, 1'b0, 32'h0);
    step();
    step();
    resetn = 1'b1;
    step();
  endtask

  initial begin
    do_reset();
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_oreq_valid", {31'b0, oreq_valid}, 32'd0);
    check("rst_iresp_ready", {31'b0, iresp_ready}, 32'd0);
    check("rst_oreq_addr", oreq_addr, 32'h0);

    // kseg0 single read
    set_req(1'b1, 1'b0, 32'h8000_1234, 4'd0);
    set_resp(1'b1, 1'b1, 32'h0);
    #1;
    check("k0_capture_valid", {31'b0, oreq_valid}, 32'd0);
    check("k0_capture_ready", {31'b0, iresp_ready}, 32'd0);
    set_resp(1'b0, 1'b0, 32'h0);
    step();
    ireq_valid = 1'b0;
    #1;
    check("k0_valid", {31'b0, oreq_valid}, 32'd1);
    check("k0_addr", oreq_addr, 32'h0000_1234);
    set_resp(1'b1, 1'b1, 32'hCAFE_0001);
    #1;
    check("k0_iresp_last", {31'b0, iresp_last}, 32'd1);
    check("k0_iresp_data", iresp_data, 32'hCAFE_0001);
    step();
    set_resp(1'b0, 1'b0, 32'h0);
    #1;
    check("k0_idle", {31'b0, busy}, 32'd0);
    check("k0_err", {31'b0, err}, 32'd0);

    // kseg1 burst read with stalls
    set_req(1'b1, 1'b0, 32'hBFC0_0000, 4'd3);
    step();
    ireq_valid = 1'b0;
    #1;
    check("k1_addr", oreq_addr, 32'h1FC0_0000);
    check("k1_len", {28'b0, oreq_len}, 32'd3);
    for (int i = 0; i < 4; i++) begin
      set_resp(1'b0, 1'b0, 32'h0);
      #1;
      check("k1_stall_ready", {31'b0, iresp_ready}, 32'd0);
      check("k1_stall_busy", {31'b0, busy}, 32'd1);
      step();
      set_resp(1'b1, (i == 3), 32'hD000_0000 + i);
      #1;
      check("k1_beat_ready", {31'b0, iresp_ready}, 32'd1);
      check("k1_beat_last", {31'b0, iresp_last}, (i == 3) ? 32'd1 : 32'd0);
      check("k1_beat_data", iresp_data, 32'hD000_0000 + i);
      step();
    end
    set_resp(1'b0, 1'b0, 32'h0);
    #1;
    check("k1_busy_after", {31'b0, busy}, 32'd0);
    check("k1_err", {31'b0, err}, 32'd0);

    // kuseg write burst, ireq fields change mid-burst
    set_req(1'b1, 1'b1, 32'h0040_0010, 4'd1);
    ireq_data = 32'hAAAA_AAAA;
    step();
    ireq_valid = 1'b0;
    ireq_addr  = 32'h8765_4321;
    ireq_len   = 4'd7;
    #1;
    check("wr_addr", oreq_addr, 32'h0040_0010);
    check("wr_is_write", {31'b0, oreq_is_write}, 32'd1);
    check("wr_data0", oreq_data, 32'hAAAA_AAAA);
    set_resp(1'b1, 1'b0, 32'h0);
    step();
    ireq_data = 32'h5555_5555;
    set_resp(1'b1, 1'b1, 32'h0);
    #1;
    check("wr_data1", oreq_data, 32'h5555_5555);
    check("wr_addr_held", oreq_addr, 32'h0040_0010);
    check("wr_len_held", {28'b0, oreq_len}, 32'd1);
    step();
    set_resp(1'b0, 1'b0, 32'h0);
    #1;
    check("wr_idle", {31'b0, busy}, 32'd0);
    check("wr_err", {31'b0, err}, 32'd0);

    // kseg2 identity mapping
    set_req(1'b1, 1'b0, 32'hC000_0004, 4'd0);
    step();
    ireq_valid = 1'b0;
    #1;
    check("k2_addr", oreq_addr, 32'hC000_0004);
    set_resp(1'b1, 1'b1, 32'h0);
    step();
    set_resp(1'b0, 1'b0, 32'h0);

    // Back-to-back: second valid the cycle after the first's last
    set_req(1'b1, 1'b0, 32'h9000_0040, 4'd0);
    step();
    ireq_valid = 1'b0;
    #1;
    check("b2b_a_addr", oreq_addr, 32'h1000_0040);
    set_resp(1'b1, 1'b1, 32'h0);
    step();
    set_resp(1'b0, 1'b0, 32'h0);
    set_req(1'b1, 1'b0, 32'hA000_0100, 4'd0);
    #1;
    check("b2b_gap_valid", {31'b0, oreq_valid}, 32'd0);
    step();
    ireq_valid = 1'b0;
    #1;
    check("b2b_b_valid", {31'b0, oreq_valid}, 32'd1);
    check("b2b_b_addr", oreq_addr, 32'h0000_0100);
    set_resp(1'b1, 1'b1, 32'h0);
    step();
    set_resp(1'b0, 1'b0, 32'h0);
    #1;
    check("b2b_err", {31'b0, err}, 32'd0);

    // Reset mid-burst at beat 2
    set_req(1'b1, 1'b0, 32'h8000_0000, 4'd3);
    step();
    ireq_valid = 1'b0;
    set_resp(1'b1, 1'b0, 32'h0);
    step();
    set_resp(1'b1, 1'b0, 32'h0);
    #1;
    check("mid_valid_before", {31'b0, oreq_valid}, 32'd1);
    resetn = 1'b0;
    #1;
    check("mid_valid_async", {31'b0, oreq_valid}, 32'd0);
    check("mid_busy_async", {31'b0, busy}, 32'd0);
    set_resp(1'b0, 1'b0, 32'h0);
    step();
    resetn = 1'b1;
    step();
    check("mid_err_after", {31'b0, err}, 32'd0);
    check("mid_idle_after", {31'b0, busy}, 32'd0);
    set_req(1'b1, 1'b0, 32'hBFC0_0010, 4'd0);
    step();
    ireq_valid = 1'b0;
    #1;
    check("mid_fresh_addr", oreq_addr, 32'h1FC0_0010);
    set_resp(1'b1, 1'b1, 32'h0);
    step();
    set_resp(1'b0, 1'b0, 32'h0);
    #1;
    check("mid_fresh_err", {31'b0, err}, 32'd0);

    // Early last: len=3, last on beat 2
    set_req(1'b1, 1'b0, 32'h0000_0100, 4'd3);
    step();
    ireq_valid = 1'b0;
    set_resp(1'b1, 1'b0, 32'h0);
    step();
    set_resp(1'b1, 1'b1, 32'h0);
    step();
    set_resp(1'b0, 1'b0, 32'h0);
    #1;
    check("early_err", {31'b0, err}, 32'd1);
    check("early_idle", {31'b0, busy}, 32'd0);
    set_req(1'b1, 1'b0, 32'h0000_0200, 4'd0);
    step();
    ireq_valid = 1'b0;
    set_resp(1'b1, 1'b1, 32'h0);
    step();
    set_resp(1'b0, 1'b0, 32'h0);
    #1;
    check("early_err_sticky", {31'b0, err}, 32'd1);

    // Ready while IDLE
    do_reset();
    check("idle_err_clear", {31'b0, err}, 32'd0);
    set_resp(1'b1, 1'b0, 32'h0);
    step();
    set_resp(1'b0, 1'b0, 32'h0);
    #1;
    check("idle_ready_err", {31'b0, err}, 32'd1);

    // Overrun: len=0, first beat without last
    do_reset();
    set_req(1'b1, 1'b0, 32'h0000_0300, 4'd0);
    step();
    ireq_valid = 1'b0;
    set_resp(1'b1, 1'b0, 32'h0);
    step();
    set_resp(1'b0, 1'b0, 32'h0);
    #1;
    check("overrun_err", {31'b0, err}, 32'd1);
    check("overrun_still_busy", {31'b0, busy}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
